// File: rtl/eviction_wb_ctrl_if.sv
// Cache-side and pmem-side handshake bundle for the eviction write-back controller.
// The controller uses the slave modport; the cache/pmem/buffer environment uses master.
interface eviction_wb_ctrl_if #(
   parameter int WIDTH  = 128,
   parameter int ADDR_W = 16
);
   logic              cache_read;
   logic              cache_write;
   logic [ADDR_W-1:0] cache_address;
   logic              cache_resp;
   logic [WIDTH-1:0]  cache_rdata;
   logic              buf_load;
   logic [WIDTH-1:0]  buf_rdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [WIDTH-1:0]  pmem_wdata;
   logic [WIDTH-1:0]  pmem_rdata;
   logic              pmem_resp;
   logic              wb_pending;

   modport slave (
      input  cache_read, cache_write, cache_address, buf_rdata, pmem_rdata, pmem_resp,
      output cache_resp, cache_rdata, buf_load, pmem_read, pmem_write, pmem_address,
             pmem_wdata, wb_pending
   );

   modport master (
      output cache_read, cache_write, cache_address, buf_rdata, pmem_rdata, pmem_resp,
      input  cache_resp, cache_rdata, buf_load, pmem_read, pmem_write, pmem_address,
             pmem_wdata, wb_pending
   );
endinterface

// File: rtl/eviction_wb_ctrl.sv
// Sequences a single-line eviction write-back buffer: accepts victims, forwards hits,
// serves fills from pmem and drains the buffered line once the cache has gone quiet.
module eviction_wb_ctrl #(
   parameter int WIDTH    = 128,
   parameter int ADDR_W   = 16,
   parameter int OFFSET_W = 4,
   parameter int WB_DELAY = 2
) (
   input logic                clk,
   input logic                rst_n,
   eviction_wb_ctrl_if.slave  bus
);
   localparam int TAG_W = ADDR_W - OFFSET_W;
   localparam int CNT_W = (WB_DELAY < 1) ? 1 : $clog2(WB_DELAY + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_WB
   } state_e;

   state_e           state_q;
   logic             buf_valid_q;
   logic [TAG_W-1:0] buf_tag_q;
   logic [CNT_W-1:0] idle_cnt_q;

   logic [TAG_W-1:0] req_tag;
   logic             buf_hit;
   logic             resp;
   logic             load;
   logic             pread;
   logic             pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [WIDTH-1:0]  rdata;

   assign req_tag = bus.cache_address[ADDR_W-1:OFFSET_W];
   assign buf_hit = buf_valid_q && (buf_tag_q == req_tag);

   // Mealy decode: the cache sees its completion in the same cycle the condition holds.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      resp   = 1'b0;
      load   = 1'b0;
      pread  = 1'b0;
      pwrite = 1'b0;
      paddr  = '0;
      rdata  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cache_write) begin
               if (!buf_valid_q) begin
                  load = 1'b1;
                  resp = 1'b1;
               end
            end else if (bus.cache_read && buf_hit) begin
               resp  = 1'b1;
               rdata = bus.buf_rdata;
            end
         end
         S_FILL: begin
            pread = 1'b1;
            paddr = {req_tag, {OFFSET_W{1'b0}}};
            if (bus.pmem_resp) begin
               resp  = 1'b1;
               rdata = bus.pmem_rdata;
            end
         end
         S_WB: begin
            pwrite = 1'b1;
            paddr  = {buf_tag_q, {OFFSET_W{1'b0}}};
         end
         default: ;
      endcase
   end

   // Outputs are held quiet while reset is asserted, even before the first reset edge.
   assign bus.cache_resp   = resp   & rst_n;
   assign bus.buf_load     = load   & rst_n;
   assign bus.pmem_read    = pread  & rst_n;
   assign bus.pmem_write   = pwrite & rst_n;
   assign bus.pmem_address = rst_n ? paddr : '0;
   assign bus.cache_rdata  = rst_n ? rdata : '0;
   assign bus.pmem_wdata   = bus.buf_rdata;
   assign bus.wb_pending   = buf_valid_q & rst_n;

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         idle_cnt_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.cache_write) begin
                  idle_cnt_q <= '0;
                  if (!buf_valid_q) begin
                     buf_valid_q <= 1'b1;
                     buf_tag_q   <= req_tag;
                  end else begin
                     state_q <= S_WB;
                  end
               end else if (bus.cache_read) begin
                  idle_cnt_q <= '0;
                  if (!buf_hit) state_q <= S_FILL;
               end else if (buf_valid_q) begin
                  // The count is compared before incrementing, so WB_DELAY=0 drains on the first idle cycle.
                  if (idle_cnt_q == CNT_W'(WB_DELAY)) state_q <= S_WB;
                  else idle_cnt_q <= idle_cnt_q + CNT_W'(1);
               end else begin
                  idle_cnt_q <= '0;
               end
            end
            S_FILL: begin
               if (bus.pmem_resp) state_q <= S_IDLE;
            end
            S_WB: begin
               if (bus.pmem_resp) begin
                  buf_valid_q <= 1'b0;
                  idle_cnt_q  <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eviction_wb_ctrl.sv
// Cycle-by-cycle vector table with a scoreboard queue, plus a bounded drain sequence
// for the eviction write-back controller.
module tb_eviction_wb_ctrl;
   localparam int WIDTH    = 128;
   localparam int ADDR_W   = 16;
   localparam int WB_DELAY = 2;

   localparam logic [WIDTH-1:0] Z  = '0;
   localparam logic [WIDTH-1:0] L1 = {8{16'h1111}};
   localparam logic [WIDTH-1:0] L2 = {8{16'h7777}};
   localparam logic [WIDTH-1:0] L3 = {8{16'h2222}};
   localparam logic [WIDTH-1:0] A5 = {16{8'hA5}};

   typedef struct {
      logic              resp, load, pread, pwrite;
      logic [ADDR_W-1:0] paddr;
      logic              pend;
      logic [WIDTH-1:0]  rdata, pwdata;
   } exp_t;

   typedef struct {
      logic              rst_n, rd, wr;
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  wdata;
      logic              presp;
      logic [WIDTH-1:0]  prdata;
      exp_t              e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [WIDTH-1:0] cache_wdata;
   logic [WIDTH-1:0] buf_q = '0;
   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   exp_t sb[$];

   eviction_wb_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   eviction_wb_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .OFFSET_W(4), .WB_DELAY(WB_DELAY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Model of the separate buffer instance: loads cache write data on buf_load.
   always @(posedge clk) if (bus.buf_load) buf_q <= cache_wdata;
   assign bus.buf_rdata = buf_q;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic r, rd, wr, input logic [ADDR_W-1:0] addr,
                              input logic [WIDTH-1:0] wdata, input logic presp,
                              input logic [WIDTH-1:0] prdata, input logic resp, load, pread, pwrite,
                              input logic [ADDR_W-1:0] paddr, input logic pend,
                              input logic [WIDTH-1:0] rdata, pwdata);
      vec_t t;
      t.rst_n = r; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
      t.presp = presp; t.prdata = prdata;
      t.e.resp = resp; t.e.load = load; t.e.pread = pread; t.e.pwrite = pwrite;
      t.e.paddr = paddr; t.e.pend = pend; t.e.rdata = rdata; t.e.pwdata = pwdata;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      rst_n             = t.rst_n;
      bus.cache_read    = t.rd;
      bus.cache_write   = t.wr;
      bus.cache_address = t.addr;
      cache_wdata       = t.wdata;
      bus.pmem_resp     = t.presp;
      bus.pmem_rdata    = t.prdata;
   endtask

   task automatic compare(input int row);
      exp_t e;
      e = sb.pop_front();
      check($sformatf("r%0d cache_resp", row),   WIDTH'(bus.cache_resp),   WIDTH'(e.resp));
      check($sformatf("r%0d buf_load", row),     WIDTH'(bus.buf_load),     WIDTH'(e.load));
      check($sformatf("r%0d pmem_read", row),    WIDTH'(bus.pmem_read),    WIDTH'(e.pread));
      check($sformatf("r%0d pmem_write", row),   WIDTH'(bus.pmem_write),   WIDTH'(e.pwrite));
      check($sformatf("r%0d pmem_address", row), WIDTH'(bus.pmem_address), WIDTH'(e.paddr));
      check($sformatf("r%0d wb_pending", row),   WIDTH'(bus.wb_pending),   WIDTH'(e.pend));
      check($sformatf("r%0d cache_rdata", row),  bus.cache_rdata,          e.rdata);
      check($sformatf("r%0d pmem_wdata", row),   bus.pmem_wdata,           e.pwdata);
   endtask

   initial begin
      int idle_n;
      bit seen;
      //                rst rd wr addr      wdata presp prdata | resp ld prd pwr paddr    pend rdata pwdata
      vecs.push_back(v(0, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 0, Z,  Z));   // reset
      vecs.push_back(v(0, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 0, Z,  Z));
      vecs.push_back(v(1, 0, 1, 16'h1230, L1, 0, Z,   1, 1, 0, 0, 16'h0000, 0, Z,  Z));   // empty evict
      for (int i = 0; i < 3; i++)                                                           // idle count-up
         vecs.push_back(v(1, 0, 0, 16'h0000, Z, 0, Z, 0, 0, 0, 0, 16'h0000, 1, Z, L1));
      for (int i = 0; i < 4; i++)                                                           // drain in flight
         vecs.push_back(v(1, 0, 0, 16'h0000, Z, 0, Z, 0, 0, 0, 1, 16'h1230, 1, Z, L1));
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  1, Z,   0, 0, 0, 1, 16'h1230, 1, Z,  L1));  // 5th cycle resp
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 0, Z,  L1));
      vecs.push_back(v(1, 0, 1, 16'h1230, L1, 0, Z,   1, 1, 0, 0, 16'h0000, 0, Z,  L1));
      vecs.push_back(v(1, 1, 0, 16'h1238, Z,  0, Z,   1, 0, 0, 0, 16'h0000, 1, L1, L1));  // forward hit
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 1, Z,  L1));
      vecs.push_back(v(1, 1, 0, 16'h4560, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 1, Z,  L1));  // fill miss
      vecs.push_back(v(1, 1, 0, 16'h4560, Z,  0, Z,   0, 0, 1, 0, 16'h4560, 1, Z,  L1));
      vecs.push_back(v(1, 1, 0, 16'h4560, Z,  1, A5,  1, 0, 1, 0, 16'h4560, 1, A5, L1));
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 1, Z,  L1));
      vecs.push_back(v(1, 0, 1, 16'h7770, L2, 0, Z,   0, 0, 0, 0, 16'h0000, 1, Z,  L1));  // full-buffer evict
      vecs.push_back(v(1, 0, 1, 16'h7770, L2, 0, Z,   0, 0, 0, 1, 16'h1230, 1, Z,  L1));
      vecs.push_back(v(1, 0, 1, 16'h7770, L2, 1, Z,   0, 0, 0, 1, 16'h1230, 1, Z,  L1));
      vecs.push_back(v(1, 0, 1, 16'h7770, L2, 0, Z,   1, 1, 0, 0, 16'h0000, 0, Z,  L1));
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 1, Z,  L2));
      vecs.push_back(v(1, 1, 0, 16'h7774, Z,  0, Z,   1, 0, 0, 0, 16'h0000, 1, L2, L2));  // new tag hits
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(1, 0, 0, 16'h0000, Z, 0, Z, 0, 0, 0, 0, 16'h0000, 1, Z, L2));
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 1, 16'h7770, 1, Z,  L2));
      vecs.push_back(v(0, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 0, Z,  L2));  // reset mid-WB
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  1, Z,   0, 0, 0, 0, 16'h0000, 0, Z,  L2));  // late resp ignored
      vecs.push_back(v(1, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 0, 0, 16'h0000, 0, Z,  L2));
      vecs.push_back(v(1, 1, 1, 16'h2220, L3, 0, Z,   1, 1, 0, 0, 16'h0000, 0, Z,  L2));  // write wins
      vecs.push_back(v(1, 1, 0, 16'h2220, Z,  0, Z,   1, 0, 0, 0, 16'h0000, 1, L3, L3));  // pending read hits

      foreach (vecs[i]) begin
         drive(vecs[i]);
         sb.push_back(vecs[i].e);
         @(negedge clk);
         compare(i);
         @(posedge clk);
         #1;
      end

      // Opportunistic drain of the 0x2220 line: count idle cycles until pmem_write, bounded.
      bus.cache_read  = 1'b0;
      bus.cache_write = 1'b0;
      bus.pmem_resp   = 1'b0;
      idle_n = 0;
      seen   = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (bus.pmem_write) seen = 1'b1;
         else begin
            idle_n++;
            @(posedge clk);
            #1;
         end
      end
      check("drain_seen",   WIDTH'(seen),             WIDTH'(1));
      check("drain_delay",  WIDTH'(idle_n),           WIDTH'(WB_DELAY + 1));
      check("drain_addr",   WIDTH'(bus.pmem_address), WIDTH'(16'h2220));
      check("drain_wdata",  bus.pmem_wdata,           L3);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
      end
      bus.pmem_resp = 1'b1;
      @(negedge clk);
      check("drain_held",   WIDTH'(bus.pmem_write),   WIDTH'(1));
      check("drain_noresp", WIDTH'(bus.cache_resp),   WIDTH'(0));
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      @(negedge clk);
      check("drain_done_pending", WIDTH'(bus.wb_pending), WIDTH'(0));
      check("drain_done_write",   WIDTH'(bus.pmem_write), WIDTH'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
